// File: rtl/spi_cmd_parser.sv
// spi_cmd_parser: turns received SPI bytes into short (1-byte) or long (opcode + 4-byte LE payload) command strobes.
// Optional inactivity timeout for partial long commands is enabled by defining CMD_TIMEOUT_EN.
module spi_cmd_parser #(
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [7:0] NOP_OPCODE     = 8'h7F
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        cmd_valid,
    output logic        cmd_long,
    output logic [7:0]  cmd_opcode,
    output logic [31:0] cmd_data,
    output logic        cmd_reset,
    output logic        cmd_run,
    output logic        cmd_id,
    output logic        cmd_meta,
    output logic        cmd_finish,
    output logic        busy,
    output logic        timeout_err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARG  = 2'd1;
    localparam logic [1:0] EMIT = 2'd2;

    logic [1:0]  state;
    logic [1:0]  idx;
    logic [7:0]  opcode_q;
    logic [31:0] payload;
    logic        expire;

    assign busy = state == ARG;

`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
    logic          to_q;
    assign expire      = state == ARG && !rx_valid && tcnt == TW'(TIMEOUT_CYCLES - 1);
    assign timeout_err = to_q;
    always_ff @(posedge clock) begin
        tcnt <= (reset || rx_valid || state != ARG || expire) ? '0 : tcnt + 1'b1;
        to_q <= !reset && expire;
    end
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES != 0;
    assign expire         = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            opcode_q   <= '0;
            payload    <= '0;
            cmd_valid  <= 1'b0;
            cmd_long   <= 1'b0;
            cmd_opcode <= '0;
            cmd_data   <= '0;
            cmd_reset  <= 1'b0;
            cmd_run    <= 1'b0;
            cmd_id     <= 1'b0;
            cmd_meta   <= 1'b0;
            cmd_finish <= 1'b0;
        end else begin
            cmd_valid  <= 1'b0;
            cmd_reset  <= 1'b0;
            cmd_run    <= 1'b0;
            cmd_id     <= 1'b0;
            cmd_meta   <= 1'b0;
            cmd_finish <= 1'b0;
            if (state == ARG) begin
                if (expire) begin
                    state <= IDLE;
                end else if (rx_valid) begin
                    payload[{idx, 3'b000} +: 8] <= rx_data;
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        state      <= EMIT;
                        cmd_valid  <= 1'b1;
                        cmd_long   <= 1'b1;
                        cmd_opcode <= opcode_q;
                        cmd_data   <= {rx_data, payload[23:0]};
                    end
                end
            end else begin
                // EMIT behaves like IDLE for incoming bytes so back-to-back commands are never dropped
                state <= IDLE;
                if (rx_valid && rx_data[7]) begin
                    state    <= ARG;
                    opcode_q <= rx_data;
                    payload  <= '0;
                    idx      <= '0;
                end else if (rx_valid && rx_data != NOP_OPCODE) begin
                    state      <= EMIT;
                    cmd_valid  <= 1'b1;
                    cmd_long   <= 1'b0;
                    cmd_opcode <= rx_data;
                    cmd_data   <= '0;
                    cmd_reset  <= rx_data == 8'h00;
                    cmd_run    <= rx_data == 8'h01;
                    cmd_id     <= rx_data == 8'h02;
                    cmd_meta   <= rx_data == 8'h04;
                    cmd_finish <= rx_data == 8'h05;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_cmd_parser.sv
// tb_spi_cmd_parser: random and directed byte streams checked every cycle against a queue-based command model.
module tb_spi_cmd_parser;
    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        cmd_valid, cmd_long, cmd_reset, cmd_run, cmd_id, cmd_meta, cmd_finish, busy, timeout_err;
    logic [7:0]  cmd_opcode;
    logic [31:0] cmd_data;

    spi_cmd_parser #(.TIMEOUT_CYCLES(TO), .NOP_OPCODE(8'h7F)) dut (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .cmd_valid(cmd_valid), .cmd_long(cmd_long), .cmd_opcode(cmd_opcode), .cmd_data(cmd_data),
        .cmd_reset(cmd_reset), .cmd_run(cmd_run), .cmd_id(cmd_id), .cmd_meta(cmd_meta),
        .cmd_finish(cmd_finish), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // model: bytes of the partial long command, expected outputs after each edge
    logic [7:0]  cur[$];
    int          idle_k = 0;
    logic        e_valid = 0, e_long = 0, e_reset = 0, e_run = 0, e_id = 0, e_meta = 0, e_finish = 0, e_to = 0, e_busy = 0;
    logic [7:0]  e_op = '0;
    logic [31:0] e_data = '0;

    always @(posedge clock) begin
        {e_valid, e_reset, e_run, e_id, e_meta, e_finish, e_to} = '0;
        if (reset) begin
            cur.delete();
            idle_k = 0;
            e_long = 0;
            e_op = '0;
            e_data = '0;
        end else if (rx_valid) begin
            idle_k = 0;
            if (cur.size() == 0 && !rx_data[7]) begin
                if (rx_data != 8'h7F) begin
                    e_valid = 1; e_long = 0; e_op = rx_data; e_data = '0;
                    e_reset = rx_data == 8'h00; e_run = rx_data == 8'h01; e_id = rx_data == 8'h02;
                    e_meta = rx_data == 8'h04; e_finish = rx_data == 8'h05;
                end
            end else begin
                cur.push_back(rx_data);
                if (cur.size() == 5) begin
                    e_valid = 1; e_long = 1; e_op = cur[0];
                    e_data = {cur[4], cur[3], cur[2], cur[1]};
                    cur.delete();
                end
            end
        end else if (cur.size() != 0) begin
`ifdef CMD_TIMEOUT_EN
            idle_k++;
            if (idle_k == TO) begin
                cur.delete();
                idle_k = 0;
                e_to = 1;
            end
`endif
        end
        e_busy = cur.size() != 0;
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clock) if (chk_en) begin
        cmp("cmd_valid", cmd_valid, e_valid);
        if (e_valid) cmp("cmd_long", cmd_long, e_long);
        cmp("cmd_opcode", cmd_opcode, e_op);
        cmp("cmd_data", cmd_data, e_data);
        cmp("strobes", {cmd_reset, cmd_run, cmd_id, cmd_meta, cmd_finish},
            {e_reset, e_run, e_id, e_meta, e_finish});
        cmp("busy", busy, e_busy);
        cmp("timeout_err", timeout_err, e_to);
    end

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clock); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    initial begin
        idle(2);
        reset = 1'b0;
        do_reset();
        chk_en = 1'b1;
        cmp("rst_valid", cmd_valid, 0);
        cmp("rst_busy", busy, 0);
        cmp("rst_data", cmd_data, 0);
        cmp("rst_opcode", cmd_opcode, 0);

        send(8'hC0);
        cmp("lit_busy_c0", busy, 1);
        send(8'hFF); send(8'h00); send(8'h00);
        cmp("lit_busy_b4", busy, 1);
        send(8'h00);
        cmp("lit_c0_valid", cmd_valid, 1);
        cmp("lit_c0_long", cmd_long, 1);
        cmp("lit_c0_op", cmd_opcode, 8'hC0);
        cmp("lit_c0_data", cmd_data, 32'h000000FF);
        cmp("lit_c0_busy", busy, 0);

        send(8'h81); send(8'h0F); send(8'h00); send(8'h0F); send(8'h00);
        cmp("lit_81_data", cmd_data, 32'h000F000F);
        send(8'h01);
        cmp("lit_run", {cmd_valid, cmd_run, cmd_long}, 3'b110);
        cmp("lit_run_data", cmd_data, 0);

        repeat (3) begin
            send(8'h7F);
            cmp("lit_nop", cmd_valid, 0);
        end
        send(8'h02);
        cmp("lit_id", {cmd_valid, cmd_id}, 2'b11);

        send(8'h82); send(8'hAA); send(8'h00); send(8'h00); send(8'h00);
        cmp("lit_82_data", {cmd_long, cmd_data}, {1'b1, 32'h000000AA});
        send(8'h00);
        cmp("lit_recover_reset", cmd_reset, 1);
        send(8'h00);
        idle(2);

        send(8'h80);
        idle(20);
`ifdef CMD_TIMEOUT_EN
        cmp("lit_to_busy", busy, 0);
        send(8'h05);
        cmp("lit_finish", {cmd_valid, cmd_finish}, 2'b11);
`else
        cmp("lit_wait_busy", busy, 1);
        send(8'h05);
        cmp("lit_payload05", {cmd_valid, busy}, 2'b01);
`endif

        do_reset();
        send(8'hC1); send(8'h40);
        do_reset();
        cmp("lit_midrst", {cmd_valid, busy, cmd_data}, 34'd0);
        send(8'h04);
        cmp("lit_meta", {cmd_valid, cmd_meta, cmd_long, cmd_reset}, 4'b1100);

        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 1) do_reset();
            else if (r < 4) idle($urandom_range(5, 25));
            else if (r < 40) idle(1);
            else begin
                case ($urandom_range(0, 4))
                    0: send(8'h00);
                    1: send(8'h7F);
                    2: send(8'($urandom_range(1, 5)));
                    3: send(8'h80 | 8'($urandom_range(0, 127)));
                    default: send(8'($urandom));
                endcase
            end
        end
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
